// File: rtl/udp_pkg.sv
// udp_pkg: shared definitions for the UDP transmit (and later receive) path.
//   IP_PROTO_UDP  : IP protocol number used in the checksum pseudo-header
//   UDP_HDR_LEN   : UDP header length in bytes
//   udp_state_e   : one-hot framer state encoding
//   csum_fold     : one ones'-complement end-around-carry folding step
package udp_pkg;

    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN  = 16'd8;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'b0000_0001,
        ST_SCAN  = 8'b0000_0010,
        ST_DRAIN = 8'b0000_0100,
        ST_FOLD  = 8'b0000_1000,
        ST_REQ   = 8'b0001_0000,
        ST_HEAD  = 8'b0010_0000,
        ST_DATA  = 8'b0100_0000,
        ST_DONE  = 8'b1000_0000
    } udp_state_e;

    // Adds the upper carry half back into the lower 16 bits.
    function automatic logic [31:0] csum_fold(input logic [31:0] sum);
        return {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
    endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// udp_csum_acc: 32-bit ones'-complement checksum accumulator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : load init_sum (start of a new checksum)
//   init_sum   : starting value (pseudo-header + header terms)
//   add_en     : add add_word into the accumulator
//   add_word   : 16-bit big-endian word
//   fold_en    : perform one fold step (two are needed after the last add)
//   csum       : ~sum[15:0], with 0x0000 sent as 0xFFFF; one clk behind acc
module udp_csum_acc
    import udp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [31:0] init_sum,
    input  logic        add_en,
    input  logic [15:0] add_word,
    input  logic        fold_en,
    output logic [15:0] csum
);

    logic [31:0] acc_r;
    logic [15:0] csum_r;
    logic [15:0] inv_s;

    assign inv_s = ~acc_r[15:0];
    assign csum  = csum_r;

    // Accumulator: clear has priority, then add, then fold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 32'h0000_0000;
        end else if (clear) begin
            acc_r <= init_sum;
        end else if (add_en) begin
            acc_r <= acc_r + {16'h0000, add_word};
        end else if (fold_en) begin
            acc_r <= csum_fold(acc_r);
        end
    end

    // Registered final checksum; a zero result is transmitted as all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_r <= 16'h0000;
        end else begin
            csum_r <= (inv_s == 16'h0000) ? 16'hFFFF : inv_s;
        end
    end

endmodule

// File: rtl/udp_tx.sv
// udp_tx: UDP transmit framer. Scans the staged payload once to build the
// checksum, requests the IP layer, then streams 8 header bytes + payload.
//   clk, rst_n            : clock, asynchronous active-low reset
//   send_start            : one-cycle start pulse (ignored while busy)
//   send_length           : payload length N
//   src_port, dst_port    : UDP ports
//   ip_src_addr/dst_addr  : pseudo-header addresses
//   ram_rd_addr/rd_data   : payload RAM port, 1 clk read latency
//   udp_tx_req/ip_tx_ack  : request to / grant from the IP layer
//   udp_tx_length         : N+8 while a frame is in progress
//   udp_tx_data/valid/last: byte stream
//   busy, done, len_error : status
module udp_tx
    import udp_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472,
    parameter int ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send_start,
    input  logic [15:0]       send_length,
    input  logic [15:0]       src_port,
    input  logic [15:0]       dst_port,
    input  logic [31:0]       ip_src_addr,
    input  logic [31:0]       ip_dst_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    output logic              udp_tx_req,
    input  logic              ip_tx_ack,
    output logic [15:0]       udp_tx_length,
    output logic [7:0]        udp_tx_data,
    output logic              udp_tx_valid,
    output logic              udp_tx_last,
    output logic              busy,
    output logic              done,
    output logic              len_error
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    udp_state_e state_r, state_nx;

    logic [15:0]       len_r, sport_r, dport_r, length_r, cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              s1_r, s1_last_r, s2_r, s2_last_r, phase_r;
    logic [7:0]        hi_r, data_r;
    logic              req_r, valid_r, last_r, busy_r, done_r, err_r;

    logic [15:0]       length_nx, cnt_nx, emit_idx_s, emit_off_s;
    logic [ADDR_W-1:0] addr_nx;
    logic              s1_nx, s1_last_nx, req_nx, valid_nx, last_nx;
    logic              busy_nx, done_nx, err_nx, emit_s, accept_s, fold_s;
    logic [7:0]        data_nx;

    logic [15:0]       len8_s, addr16_s, last_idx_s, csum_s, word_s;
    logic [31:0]       init_sum_s;
    logic              len_ok_s, add_s;

    assign len8_s     = send_length + UDP_HDR_LEN;
    assign len_ok_s   = (send_length != 16'd0) && (send_length <= MAX_LEN);
    assign addr16_s   = {{(16-ADDR_W){1'b0}}, addr_r};
    assign last_idx_s = len_r + 16'd7;

    // Pseudo-header + header terms; the UDP length appears twice by definition.
    assign init_sum_s = {16'h0000, ip_src_addr[31:16]} + {16'h0000, ip_src_addr[15:0]}
                      + {16'h0000, ip_dst_addr[31:16]} + {16'h0000, ip_dst_addr[15:0]}
                      + {24'h000000, IP_PROTO_UDP} + {16'h0000, len8_s}
                      + {16'h0000, src_port} + {16'h0000, dst_port}
                      + {16'h0000, len8_s};

    // Bytes pair big-endian; an odd trailing byte is padded with zero.
    assign add_s  = s2_r && (phase_r || s2_last_r);
    assign word_s = phase_r ? {hi_r, ram_rd_data} : {ram_rd_data, 8'h00};

    udp_csum_acc u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept_s),
        .init_sum (init_sum_s),
        .add_en   (add_s),
        .add_word (word_s),
        .fold_en  (fold_s),
        .csum     (csum_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx   = state_r;
        accept_s   = 1'b0;
        fold_s     = 1'b0;
        emit_s     = 1'b0;
        emit_idx_s = 16'd0;
        emit_off_s = 16'd0;
        addr_nx    = '0;
        s1_nx      = 1'b0;
        s1_last_nx = 1'b0;
        req_nx     = 1'b0;
        valid_nx   = 1'b0;
        last_nx    = 1'b0;
        data_nx    = 8'h00;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        busy_nx    = busy_r;
        length_nx  = length_r;
        cnt_nx     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                busy_nx   = 1'b0;
                length_nx = 16'd0;
                // busy_r is still high during the done cycle; starts are ignored then.
                if (send_start && !busy_r) begin
                    if (len_ok_s) begin
                        accept_s   = 1'b1;
                        state_nx   = ST_SCAN;
                        busy_nx    = 1'b1;
                        length_nx  = len8_s;
                        s1_nx      = 1'b1;
                        s1_last_nx = (send_length == 16'd1);
                    end else begin
                        err_nx = 1'b1;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (addr16_s + 16'd1 == len_r) begin
                    state_nx = ST_DRAIN;
                end else begin
                    addr_nx    = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    s1_nx      = 1'b1;
                    s1_last_nx = (addr16_s + 16'd2 == len_r);
                end
            end
            ST_DRAIN: begin
                cnt_nx = 16'd0;
                if (s2_r && s2_last_r) begin
                    state_nx = ST_FOLD;
                end else begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_FOLD: begin
                fold_s = 1'b1;
                cnt_nx = cnt_r + 16'd1;
                if (cnt_r == 16'd1) begin
                    state_nx = ST_REQ;
                    req_nx   = 1'b1;
                end else begin
                    state_nx = ST_FOLD;
                end
            end
            ST_REQ: begin
                if (ip_tx_ack) begin
                    emit_s   = 1'b1;
                    state_nx = ST_HEAD;
                end else begin
                    req_nx = 1'b1;
                end
            end
            ST_HEAD, ST_DATA: begin
                emit_s     = 1'b1;
                emit_idx_s = cnt_r;
                if (cnt_r == last_idx_s) begin
                    state_nx = ST_DONE;
                end else if (cnt_r == 16'd7) begin
                    state_nx = ST_DATA;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_DONE: begin
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Byte emission; payload address is issued 2 clk ahead of its byte slot.
        if (emit_s) begin
            valid_nx   = 1'b1;
            cnt_nx     = emit_idx_s + 16'd1;
            last_nx    = (emit_idx_s == last_idx_s);
            emit_off_s = emit_idx_s - 16'd6;
            if (emit_idx_s < 16'd8) begin
                case (emit_idx_s[2:0])
                    3'd0:    data_nx = sport_r[15:8];
                    3'd1:    data_nx = sport_r[7:0];
                    3'd2:    data_nx = dport_r[15:8];
                    3'd3:    data_nx = dport_r[7:0];
                    3'd4:    data_nx = length_r[15:8];
                    3'd5:    data_nx = length_r[7:0];
                    3'd6:    data_nx = csum_s[15:8];
                    3'd7:    data_nx = csum_s[7:0];
                    default: data_nx = 8'h00;
                endcase
            end else begin
                data_nx = ram_rd_data;
            end
            if ((emit_idx_s >= 16'd6) && (emit_off_s < len_r)) begin
                addr_nx = emit_off_s[ADDR_W-1:0];
            end else begin
                addr_nx = '0;
            end
        end else begin
            valid_nx = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r     <= 16'd0;
            sport_r   <= 16'd0;
            dport_r   <= 16'd0;
            length_r  <= 16'd0;
            cnt_r     <= 16'd0;
            addr_r    <= '0;
            s1_r      <= 1'b0;
            s1_last_r <= 1'b0;
            s2_r      <= 1'b0;
            s2_last_r <= 1'b0;
            phase_r   <= 1'b0;
            hi_r      <= 8'h00;
            data_r    <= 8'h00;
            req_r     <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            length_r  <= length_nx;
            cnt_r     <= cnt_nx;
            addr_r    <= addr_nx;
            s1_r      <= s1_nx;
            s1_last_r <= s1_last_nx;
            s2_r      <= s1_r;
            s2_last_r <= s1_last_r;
            data_r    <= data_nx;
            req_r     <= req_nx;
            valid_r   <= valid_nx;
            last_r    <= last_nx;
            busy_r    <= busy_nx;
            done_r    <= done_nx;
            err_r     <= err_nx;
            if (accept_s) begin
                len_r   <= send_length;
                sport_r <= src_port;
                dport_r <= dst_port;
                phase_r <= 1'b0;
            end else if (s2_r) begin
                if (!phase_r && !s2_last_r) begin
                    hi_r    <= ram_rd_data;
                    phase_r <= 1'b1;
                end else begin
                    phase_r <= 1'b0;
                end
            end
        end
    end

    assign ram_rd_addr   = addr_r;
    assign udp_tx_req    = req_r;
    assign udp_tx_length = length_r;
    assign udp_tx_data   = data_r;
    assign udp_tx_valid  = valid_r;
    assign udp_tx_last   = last_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign len_error     = err_r;

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed self-checking bench for udp_tx with a 1-clk-latency RAM model.
module tb_udp_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send_start;
    logic [15:0] send_length, src_port, dst_port;
    logic [31:0] ip_src_addr, ip_dst_addr;
    logic [10:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic        udp_tx_req, ip_tx_ack;
    logic [15:0] udp_tx_length;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_valid, udp_tx_last, busy, done, len_error;

    logic [7:0]  mem [0:2047];
    logic [7:0]  cap_q [$];
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt, lerr_cnt, last_cnt, last_pos, bubble_cnt;
    bit          req_seen, busy_seen, prev_v, prev_l;

    udp_tx #(.MAX_PAYLOAD(1472), .ADDR_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .send_start(send_start), .send_length(send_length),
        .src_port(src_port), .dst_port(dst_port), .ip_src_addr(ip_src_addr),
        .ip_dst_addr(ip_dst_addr), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .udp_tx_req(udp_tx_req), .ip_tx_ack(ip_tx_ack), .udp_tx_length(udp_tx_length),
        .udp_tx_data(udp_tx_data), .udp_tx_valid(udp_tx_valid), .udp_tx_last(udp_tx_last),
        .busy(busy), .done(done), .len_error(len_error)
    );

    always #5 clk = ~clk;

    // Payload RAM: synchronous read, data one clk after the address.
    always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

    // Stream monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (udp_tx_valid) begin
            cap_q.push_back(udp_tx_data);
            if (udp_tx_last) begin
                last_cnt++;
                last_pos = cap_q.size() - 1;
            end
        end
        if (prev_v && !prev_l && !udp_tx_valid) bubble_cnt++;
        prev_v = udp_tx_valid;
        prev_l = udp_tx_last;
        if (done) done_cnt++;
        if (len_error) lerr_cnt++;
        if (udp_tx_req) req_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{ram_rd_addr, udp_tx_req, udp_tx_length, udp_tx_data,
                 udp_tx_valid, udp_tx_last, busy, done, len_error};
    endfunction

    task automatic clear_mon();
        cap_q.delete();
        done_cnt = 0; lerr_cnt = 0; last_cnt = 0; last_pos = -1; bubble_cnt = 0;
        req_seen = 1'b0; busy_seen = 1'b0; prev_v = 1'b0; prev_l = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(negedge clk);
        send_length = len;
        send_start  = 1'b1;
        @(negedge clk);
        send_start  = 1'b0;
    endtask

    task automatic wait_req(input int n);
        int lat = 0;
        while (!udp_tx_req && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("req_latency_ok", 32'(udp_tx_req && (lat <= n + 6)), 32'd1);
        check("req_length", 32'(udp_tx_length), 32'(n + 8));
    endtask

    task automatic give_ack(input int delay);
        int drop = 0;
        int early = 0;
        repeat (delay) begin
            @(negedge clk);
            if (!udp_tx_req) drop++;
            if (udp_tx_valid) early++;
        end
        ip_tx_ack = 1'b1;
        @(negedge clk);
        ip_tx_ack = 1'b0;
        check("first_byte_after_ack", 32'(udp_tx_valid), 32'd1);
        check("req_drop_after_ack", 32'(udp_tx_req), 32'd0);
        if (delay > 0) begin
            check("req_held", 32'(drop), 32'd0);
            check("no_valid_before_ack", 32'(early), 32'd0);
        end
    endtask

    task automatic wait_done();
        int i = 0;
        while (!done && i < 4000) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cap(input int k);
        int i = 0;
        while (cap_q.size() < k && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("cap_reached", 32'(cap_q.size() >= k), 32'd1);
    endtask

    task automatic cmp_frame(input int n);
        logic [7:0] b;
        check("valid_count", 32'(cap_q.size()), 32'(n + 8));
        for (int i = 0; i < exp_q.size(); i++) begin
            b = (i < cap_q.size()) ? cap_q[i] : 8'h5A;
            check($sformatf("byte%0d", i), 32'(b), 32'(exp_q[i]));
        end
        check("last_count", 32'(last_cnt), 32'd1);
        check("last_pos", 32'(last_pos), 32'(n + 7));
        check("done_count", 32'(done_cnt), 32'd1);
        check("no_bubble", 32'(bubble_cnt), 32'd0);
        check("idle_outputs", 32'(any_out()), 32'd0);
    endtask

    task automatic load_p4();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
        exp_q = '{8'h1F, 8'h90, 8'h1F, 8'h90, 8'h00, 8'h0C, 8'h38, 8'hF1,
                  8'h01, 8'h02, 8'h03, 8'h04};
    endtask

    initial begin
        rst_n = 1'b0; send_start = 1'b0; send_length = 16'd0; ip_tx_ack = 1'b0;
        src_port = 16'h1F90; dst_port = 16'h1F90;
        ip_src_addr = 32'hC0A8_010A; ip_dst_addr = 32'hC0A8_0164;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(any_out()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(any_out()), 32'd0);

        // N=4 basic frame, immediate grant.
        load_p4();
        clear_mon();
        pulse_start(16'd4);
        wait_req(4);
        give_ack(0);
        wait_done();
        cmp_frame(4);

        // N=3 odd length, padded last word.
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
        exp_q = '{8'h1F, 8'h90, 8'h1F, 8'h90, 8'h00, 8'h0B, 8'hC6, 8'h3C,
                  8'hAA, 8'hBB, 8'hCC};
        clear_mon();
        pulse_start(16'd3);
        wait_req(3);
        give_ack(0);
        wait_done();
        cmp_frame(3);

        // Grant delayed by 20 clk.
        load_p4();
        clear_mon();
        pulse_start(16'd4);
        wait_req(4);
        give_ack(20);
        wait_done();
        cmp_frame(4);

        // Illegal lengths.
        clear_mon();
        pulse_start(16'd0);
        repeat (5) @(negedge clk);
        check("len0_error", 32'(lerr_cnt), 32'd1);
        check("len0_no_req", 32'(req_seen), 32'd0);
        check("len0_no_busy", 32'(busy_seen), 32'd0);
        clear_mon();
        pulse_start(16'd1473);
        repeat (5) @(negedge clk);
        check("len1473_error", 32'(lerr_cnt), 32'd1);
        check("len1473_no_req", 32'(req_seen), 32'd0);
        check("len1473_no_busy", 32'(busy_seen), 32'd0);

        // Second start mid-DATA is ignored.
        clear_mon();
        pulse_start(16'd4);
        wait_req(4);
        give_ack(0);
        wait_cap(9);
        pulse_start(16'd3);
        send_length = 16'd4;
        wait_done();
        cmp_frame(4);
        req_seen = 1'b0;
        repeat (10) @(negedge clk);
        check("no_second_frame", 32'(req_seen || busy), 32'd0);

        // Asynchronous reset at header byte 3, then a fresh frame.
        clear_mon();
        pulse_start(16'd4);
        wait_req(4);
        give_ack(0);
        wait_cap(4);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(any_out()), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", 32'(any_out()), 32'd0);
        clear_mon();
        pulse_start(16'd4);
        wait_req(4);
        give_ack(0);
        wait_done();
        cmp_frame(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx.md
Name: udp_tx

Overview:
UDP transmit framer, the send-side counterpart of the UDP receive path. It reads a payload already staged in a byte RAM and computes the UDP checksum over the pseudo-header, UDP header and payload in a first pass. It then requests the IP layer and streams the 8-byte UDP header followed by the payload, one byte per clk. It sits between the application payload buffer and ip_tx.

Parameters:
MAX_PAYLOAD, 1472, largest accepted payload in bytes (Ethernet MTU minus IP/UDP headers)
ADDR_W, 11, payload RAM address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
send_start  in  1  one-cycle pulse; sample length, ports, addresses; begin frame
send_length  in  16  payload byte count N
src_port  in  16  UDP source port
dst_port  in  16  UDP destination port
ip_src_addr  in  32  pseudo-header source IP
ip_dst_addr  in  32  pseudo-header destination IP
ram_rd_addr  out  ADDR_W  payload RAM read address; data returns 1 clk later
ram_rd_data  in  8  payload RAM read data
udp_tx_req  out  1  request to IP layer; level, held until ip_tx_ack
ip_tx_ack  in  1  one-cycle grant from IP layer; first byte follows next clk
udp_tx_length  out  16  UDP length (N+8), valid while udp_tx_req=1 and during send
udp_tx_data  out  8  byte stream to IP layer
udp_tx_valid  out  1  udp_tx_data valid
udp_tx_last  out  1  marks final byte
busy  out  1  high from accepted send_start until the done cycle inclusive
done  out  1  one-cycle pulse after last byte
len_error  out  1  one-cycle pulse: N==0 or N>MAX_PAYLOAD; no frame sent

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator cleared. Async reset mid-frame aborts immediately; no partial byte after release.
- send_start while busy: ignored. Inputs are registered on acceptance; later changes have no effect.
- FSM: IDLE -> (start, N legal) SCAN; (start, N illegal) pulse len_error, stay IDLE.
- SCAN: issue ram_rd_addr 0..N-1 on consecutive cycles. Pair bytes big-endian into 16-bit words. For odd N, pad the last byte as {byte,8'h00}. Accumulate into a 32-bit sum -> FOLD.
- Initial sum = src_ip[31:16] + src_ip[15:0] + dst_ip[31:16] + dst_ip[15:0] + 16'h0011 + (N+8) + src_port + dst_port + (N+8).
- FOLD: two cycles of sum = sum[15:0] + sum[31:16]. Checksum = ~sum[15:0]; a computed 0x0000 is transmitted as 0xFFFF -> REQ.
- REQ: udp_tx_req=1 until ip_tx_ack. udp_tx_req must assert no later than N+6 clk after send_start -> HEAD.
- HEAD: 8 consecutive valid bytes: src_port hi/lo, dst_port hi/lo, length hi/lo, checksum hi/lo.
- DATA: N consecutive valid bytes, RAM addresses 0..N-1. Prefetch so there are no bubbles between HEAD and DATA or inside DATA. udp_tx_last on byte N+7 (0-based).
- END: done pulse; busy drops the next cycle -> IDLE.
- udp_tx_valid never deasserts mid-frame. Total valid cycles = N+8.
- ram_rd_addr holds 0 when not reading.
- Arithmetic: 16-bit length add wraps are impossible within MAX_PAYLOAD. The accumulator is 32 bits, so it cannot overflow at N ≤ 1472.

Decomposition:
- Package udp_pkg: IP_PROTO_UDP=8'd17, UDP_HDR_LEN=16'd8, FSM state encoding (one-hot, 8 states), ones'-complement fold function.
- Sub-module udp_csum_acc: clear, add 16-bit word, two-cycle fold, outputs final inverted checksum with the 0→FFFF substitution. Reusable by udp_rx later.

Test Plan:
- N=4, payload 01 02 03 04, src 192.168.1.10, dst 192.168.1.100, ports 1F90/1F90 -> stream 1F 90 1F 90 00 0C 38 F1 01 02 03 04; last on byte 12; done once.
- N=3, payload AA BB CC, same addresses/ports -> length 000B, checksum C6 3C, bytes AA BB CC; 11 valid cycles, no bubbles.
- ip_tx_ack delayed 20 clk -> udp_tx_req held 20 clk, no udp_tx_valid before ack+1, stream identical to the first case.
- send_length 0 and 1473 -> single len_error pulse each, udp_tx_req never asserts, busy stays 0.
- send_start pulsed again mid-DATA with different N -> ignored; original frame completes unchanged.
- rst_n asserted at HEAD byte 3 -> all outputs 0 asynchronously. After release, a fresh start with N=4 reproduces the first case exactly.
